// File: rtl/router_pkg.sv
// Shared constants, types and helpers for the router read-side drain arbiter.
// Optional parity checking is selected in router_drain_arb by ROUTER_DRAIN_ARB_PARITY_EN.
package router_pkg;

  localparam int NUM_PORTS   = 3;
  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    HWAIT,
    BODY
  } drain_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] port;
    logic       sop;
    logic       eop;
    logic       perr;
  } buf_entry_t;

  // First requesting port at or after ptr, wrapping from the last port back to 0.
  function automatic logic [1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                         input logic [1:0]           ptr);
    int         idx;
    logic [1:0] idx2;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      idx2 = 2'(idx);
      if (!found && req[idx2]) begin
        rr_pick = idx2;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p >= 2'(NUM_PORTS - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/router_drain_skid.sv
// Two-entry output buffer between the FIFO read path and the backpressured
// merged stream; the caller never pushes into a full buffer without a pop.
module router_drain_skid
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_push,
  input  buf_entry_t i_entry,
  input  logic       i_pop,
  output buf_entry_t o_head,
  output logic [1:0] o_occ
);

  buf_entry_t r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_occ;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides what is
  // valid, and the top gates outputs to zero while the buffer is empty.
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/router_drain_arb.sv
// Packet-granular round-robin drain of three router FIFOs onto one tagged stream.
// Define ROUTER_DRAIN_ARB_PARITY_EN to build the running-XOR parity check on m_perr.
module router_drain_arb
  import router_pkg::*;
#(
  parameter int LEN_W = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid_out_0,
  input  logic       valid_out_1,
  input  logic       valid_out_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [1:0] m_port,
  output logic       m_sop,
  output logic       m_eop,
  output logic       m_perr
);

  localparam logic [LEN_W:0] REM_ONE = (LEN_W+1)'(1);

  drain_state_e         r_state;
  logic [1:0]           r_grant;
  logic [1:0]           r_rr_ptr;
  logic [LEN_W:0]       r_remaining;
  logic                 r_inflight;
  logic                 r_inf_sop;
  logic                 r_inf_eop;

  logic [NUM_PORTS-1:0] w_valid;
  logic [7:0]           w_rdata;
  logic [HDR_LEN_MSB-HDR_LEN_LSB:0] w_len;
  logic [1:0]           w_occ;
  logic [2:0]           w_level;
  logic                 w_pop;
  logic                 w_room;
  logic                 w_issue;
  logic                 w_is_last;
  logic                 w_perr;
  buf_entry_t           w_entry;
  buf_entry_t           w_head;

  assign w_valid = {valid_out_2, valid_out_1, valid_out_0};
  assign w_len   = w_rdata[HDR_LEN_MSB:HDR_LEN_LSB];

  always_comb begin
    case (r_grant)
      2'd1:    w_rdata = data_out_1;
      2'd2:    w_rdata = data_out_2;
      default: w_rdata = data_out_0;
    endcase
  end

  // Room check counts the byte still in flight and credits a pop this cycle.
  assign w_pop   = m_valid && m_ready;
  assign w_level = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_room  = w_level < (3'd2 + {2'b00, w_pop});

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_issue   = 1'b0;
    w_is_last = 1'b0;
    case (r_state)
      // The header read also honours buffer room, in case the previous
      // packet's tail is still waiting on a stalled consumer.
      HDR:  w_issue = w_room;
      BODY: begin
        w_issue   = w_valid[r_grant] && w_room && (r_remaining != '0);
        w_is_last = (r_remaining == REM_ONE);
      end
      default: ;
    endcase
  end

  assign read_enb_0 = w_issue && (r_grant == 2'd0);
  assign read_enb_1 = w_issue && (r_grant == 2'd1);
  assign read_enb_2 = w_issue && (r_grant == 2'd2);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grant     <= 2'd0;
      r_rr_ptr    <= 2'd0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_inf_sop   <= 1'b0;
      r_inf_eop   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_inf_sop  <= w_issue && (r_state == HDR);
      r_inf_eop  <= w_issue && w_is_last;
      case (r_state)
        IDLE: begin
          if (|w_valid) begin
            r_grant <= rr_pick(w_valid, r_rr_ptr);
            r_state <= HDR;
          end
        end
        HDR: begin
          if (w_issue) r_state <= HWAIT;
        end
        HWAIT: begin
          r_remaining <= (LEN_W+1)'(w_len) + REM_ONE;
          r_state     <= BODY;
        end
        BODY: begin
          if (w_issue) r_remaining <= r_remaining - REM_ONE;
          // Last read went out last cycle; its byte is pushed this cycle.
          if (r_remaining == '0) begin
            r_state  <= IDLE;
            r_rr_ptr <= next_port(r_grant);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ROUTER_DRAIN_ARB_PARITY_EN
  logic [7:0] r_xor;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_xor <= 8'd0;
    end else if (r_inflight) begin
      if (r_inf_sop)       r_xor <= w_rdata;
      else if (!r_inf_eop) r_xor <= r_xor ^ w_rdata;
    end
  end

  assign w_perr = r_inf_eop && (r_xor != w_rdata);
`else
  assign w_perr = 1'b0;
`endif

  assign w_entry = '{data: w_rdata, port: r_grant, sop: r_inf_sop,
                     eop: r_inf_eop, perr: w_perr};

  router_drain_skid u_skid (
    .clock   (clock),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_occ   (w_occ)
  );

  assign m_valid = (w_occ != 2'd0);
  assign m_data  = m_valid ? w_head.data : 8'd0;
  assign m_port  = m_valid ? w_head.port : 2'd0;
  assign m_sop   = m_valid && w_head.sop;
  assign m_eop   = m_valid && w_head.eop;
  assign m_perr  = m_valid && w_head.perr;

endmodule

// File: tb/tb_router_drain_arb.sv
// Directed bench for router_drain_arb: FIFO models on three ports, a beat
// monitor, a packet vector table and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_router_drain_arb;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       valid_out_0 = 1'b0, valid_out_1 = 1'b0, valid_out_2 = 1'b0;
  logic [7:0] data_out_0 = 8'd0, data_out_1 = 8'd0, data_out_2 = 8'd0;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [1:0] m_port;
  logic       m_sop, m_eop, m_perr;

  router_drain_arb dut (
    .clock(clock), .reset(reset),
    .valid_out_0(valid_out_0), .valid_out_1(valid_out_1), .valid_out_2(valid_out_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_port(m_port),
    .m_sop(m_sop), .m_eop(m_eop), .m_perr(m_perr)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  data;
    logic [1:0]  port;
    logic        sop;
    logic        eop;
    logic        perr;
    logic [31:0] cyc;
  } beat_t;

  typedef struct packed {
    logic [1:0]      port;
    logic [7:0]      hdr;
    logic [3:0][7:0] pay;
    logic [7:0]      par;
    logic            exp_perr;
    logic [3:0]      exp_beats;
  } vec_t;

  logic [7:0] q0[$], q1[$], q2[$];
  beat_t      beats[$];
  int         rd_cyc[$];
  logic [1:0] rd_port[$];
  int         cyc = 0;
  int         underflow = 0;
  int         multi_rd = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  beat_t      mon_b;
  vec_t       vecs[6];

  // Registered FIFO model: data valid the cycle after the strobe.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if ((int'(read_enb_0) + int'(read_enb_1) + int'(read_enb_2)) > 1) multi_rd++;
    if (read_enb_0) begin
      if (q0.size() == 0) underflow++; else data_out_0 <= q0.pop_front();
    end
    if (read_enb_1) begin
      if (q1.size() == 0) underflow++; else data_out_1 <= q1.pop_front();
    end
    if (read_enb_2) begin
      if (q2.size() == 0) underflow++; else data_out_2 <= q2.pop_front();
    end
    valid_out_0 <= (q0.size() != 0);
    valid_out_1 <= (q1.size() != 0);
    valid_out_2 <= (q2.size() != 0);
  end

  always @(negedge clock) begin
    if (m_valid && m_ready) begin
      mon_b = {m_data, m_port, m_sop, m_eop, m_perr, 32'(cyc)};
      beats.push_back(mon_b);
    end
    if (read_enb_0) begin rd_cyc.push_back(cyc); rd_port.push_back(2'd0); end
    if (read_enb_1) begin rd_cyc.push_back(cyc); rd_port.push_back(2'd1); end
    if (read_enb_2) begin rd_cyc.push_back(cyc); rd_port.push_back(2'd2); end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycles=%0d required<40000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic qpush(input logic [1:0] p, input logic [7:0] b);
    case (p)
      2'd0:    q0.push_back(b);
      2'd1:    q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic load(input logic [1:0] p, input logic [7:0] hdr,
                      input logic [3:0][7:0] pay, input logic [7:0] par);
    int len;
    len = int'(hdr[7:2]);
    qpush(p, hdr);
    for (int i = 0; i < len; i++) qpush(p, pay[i]);
    qpush(p, par);
  endtask

  task automatic clear_logs();
    beats.delete();
    rd_cyc.delete();
    rd_port.delete();
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    tick(2);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic wait_beats(input int n, input string name);
    int k;
    k = 0;
    while (beats.size() < n && k < 300) begin
      tick(1);
      k++;
    end
    check({name, "_timeout"}, 64'(beats.size() >= n), 64'd1);
  endtask

  function automatic logic [17:0] port_seq(input int n);
    logic [17:0] s;
    s = '0;
    for (int i = 0; i < n; i++)
      s = {s[15:0], (i < beats.size()) ? beats[i].port : 2'd3};
    return s;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] exp_b[$];
    int   len, t0, n;
    int   bad_data, bad_tag, bad_perr, bad_time, bad_rd;
    logic exp_pe;
`ifdef ROUTER_DRAIN_ARB_PARITY_EN
    exp_pe = v.exp_perr;
`else
    exp_pe = 1'b0;
`endif
    len = int'(v.hdr[7:2]);
    exp_b.push_back(v.hdr);
    for (int i = 0; i < len; i++) exp_b.push_back(v.pay[i]);
    exp_b.push_back(v.par);
    n = exp_b.size();
    clear_logs();
    load(v.port, v.hdr, v.pay, v.par);
    wait_beats(int'(v.exp_beats), $sformatf("v%0d", idx));
    tick(6);
    check($sformatf("v%0d_beat_cnt", idx), 64'(beats.size()), 64'(v.exp_beats));
    check($sformatf("v%0d_read_cnt", idx), 64'(rd_cyc.size()), 64'(v.exp_beats));
    t0 = (rd_cyc.size() > 0) ? rd_cyc[0] : 0;
    bad_data = 0; bad_tag = 0; bad_perr = 0; bad_time = 0; bad_rd = 0;
    for (int i = 0; i < n; i++) begin
      if (i < beats.size()) begin
        if (beats[i].data !== exp_b[i]) bad_data++;
        if (beats[i].port !== v.port || beats[i].sop !== (i == 0) ||
            beats[i].eop !== (i == n - 1)) bad_tag++;
        if (beats[i].perr !== ((i == n - 1) ? exp_pe : 1'b0)) bad_perr++;
        if (beats[i].cyc !== 32'((i == 0) ? t0 + 2 : t0 + 3 + i)) bad_time++;
      end
      if (i < rd_cyc.size()) begin
        if (rd_cyc[i] != ((i == 0) ? t0 : t0 + 1 + i) || rd_port[i] != v.port) bad_rd++;
      end
    end
    check($sformatf("v%0d_data", idx), 64'(bad_data), 64'd0);
    check($sformatf("v%0d_tags", idx), 64'(bad_tag), 64'd0);
    check($sformatf("v%0d_perr", idx), 64'(bad_perr), 64'd0);
    check($sformatf("v%0d_beat_timing", idx), 64'(bad_time), 64'd0);
    check($sformatf("v%0d_read_timing", idx), 64'(bad_rd), 64'd0);
  endtask

  initial begin
    int          k, stall_rd, stall_inv, stall_chg;
    logic [7:0]  held;
    logic [47:0] seq;

    //        port  hdr    payload (byte0 in LSB)  parity  perr beats
    vecs[0] = '{2'd1, 8'h0D, 32'h00C3B2A1, 8'hDD, 1'b0, 4'd5};
    vecs[1] = '{2'd2, 8'h02, 32'h00000000, 8'h02, 1'b0, 4'd2};
    vecs[2] = '{2'd0, 8'h05, 32'h00000011, 8'h15, 1'b1, 4'd3};
    vecs[3] = '{2'd0, 8'h05, 32'h00000011, 8'h14, 1'b0, 4'd3};
    vecs[4] = '{2'd2, 8'h09, 32'h00005A3C, 8'h6F, 1'b0, 4'd4};
    vecs[5] = '{2'd1, 8'h08, 32'h000000FF, 8'h00, 1'b1, 4'd4};

    tick(2);
    check("reset_outputs",
          {read_enb_2, read_enb_1, read_enb_0, m_valid, m_data, m_port, m_sop, m_eop, m_perr},
          64'd0);
    reset = 1'b0;
    tick(1);

    for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

    // Round robin: all ports pending after reset, then 0 and 2 after the wrap.
    do_reset();
    load(2'd0, 8'h05, 32'h11, 8'h14);
    load(2'd1, 8'h05, 32'h22, 8'h27);
    load(2'd2, 8'h05, 32'h33, 8'h36);
    wait_beats(9, "rr3");
    tick(4);
    check("rr3_order", 64'(port_seq(9)), 64'({2'd0,2'd0,2'd0,2'd1,2'd1,2'd1,2'd2,2'd2,2'd2}));
    clear_logs();
    load(2'd2, 8'h05, 32'h33, 8'h36);
    load(2'd0, 8'h05, 32'h11, 8'h14);
    wait_beats(6, "rr_wrap");
    tick(4);
    check("rr_wrap_order", 64'(port_seq(6)), 64'({2'd0,2'd0,2'd0,2'd2,2'd2,2'd2}));

    // Consumer stall of 4 cycles in the middle of a len-4 body.
    clear_logs();
    load(2'd0, 8'h10, 32'h04030201, 8'h14);
    k = 0;
    while (!read_enb_0 && k < 50) begin tick(1); k++; end
    check("stall_hdr_read", 64'(read_enb_0), 64'd1);
    tick(5);
    m_ready = 1'b0;
    stall_rd = 0; stall_inv = 0; stall_chg = 0; held = 8'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (read_enb_0 || read_enb_1 || read_enb_2) stall_rd++;
      if (!m_valid) stall_inv++;
      if (i == 0) held = m_data;
      else if (m_data !== held) stall_chg++;
      tick(1);
    end
    m_ready = 1'b1;
    wait_beats(6, "stall");
    tick(4);
    check("stall_reads", 64'(stall_rd), 64'd0);
    check("stall_valid_held", 64'(stall_inv), 64'd0);
    check("stall_data_held", 64'(stall_chg), 64'd0);
    check("stall_held_byte", 64'(held), 64'h02);
    check("stall_beat_cnt", 64'(beats.size()), 64'd6);
    seq = '0;
    for (int i = 0; i < 6; i++)
      seq = {seq[39:0], (i < beats.size()) ? beats[i].data : 8'hEE};
    check("stall_data_seq", 64'(seq), 64'h10_01_02_03_04_14);

    // Reset in mid-body, then lowest valid port wins.
    do_reset();
    load(2'd0, 8'h05, 32'h11, 8'h14);
    wait_beats(3, "pre_rst");
    tick(4);
    clear_logs();
    load(2'd1, 8'h10, 32'h44332211, 8'h54);
    wait_beats(3, "mid_body");
    reset = 1'b1;
    tick(1);
    check("mid_reset_outputs",
          {read_enb_2, read_enb_1, read_enb_0, m_valid, m_data, m_port, m_sop, m_eop, m_perr},
          64'd0);
    q1.delete();
    tick(1);
    reset = 1'b0;
    clear_logs();
    load(2'd1, 8'h05, 32'h22, 8'h27);
    load(2'd0, 8'h05, 32'h11, 8'h14);
    wait_beats(6, "post_rst");
    tick(4);
    check("post_rst_order", 64'(port_seq(6)), 64'({2'd0,2'd0,2'd0,2'd1,2'd1,2'd1}));

    check("fifo_underflow", 64'(underflow), 64'd0);
    check("single_read_enb", 64'(multi_rd), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_drain_arb.md
# router_drain_arb

Read-side scheduler for the router's three output FIFOs. It arbitrates among the FIFOs with packet-granular round-robin and sequences the `read_enb_0..2` strobes. It merges the drained bytes onto one backpressured output stream with port tag and packet delimiters. It sits between the router's `valid_out_N`/`data_out_N` outputs and a single downstream consumer.

## Interface
- `LEN_W`, default 6: payload length field width, taken from header bits [7:2].
- `clock`  in  1  system clock; all state is updated on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid_out_0`, `valid_out_1`, `valid_out_2`  in  1 each  FIFO N is non-empty.
- `data_out_0`, `data_out_1`, `data_out_2`  in  8 each  FIFO N read data, valid the cycle after `read_enb_N`.
- `read_enb_0`, `read_enb_1`, `read_enb_2`  out  1 each  FIFO N read strobe.
- `m_data`  out  8  merged output byte.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  consumer accepts the byte; a transfer occurs when `m_valid && m_ready`.
- `m_port`  out  2  source FIFO index of the current byte.
- `m_sop`  out  1  current byte is a header.
- `m_eop`  out  1  current byte is a parity byte (last byte of the packet).
- `m_perr`  out  1  parity mismatch, qualified by `m_eop`.

## Operation
- Packet in a FIFO: header (len = [7:2]), then len payload bytes, then 1 parity byte. Total len+2 bytes; len = 0 is legal.
- FSM states:
  - IDLE: if any `valid_out_N` is set, grant the first set port searching from `rr_ptr` upward with wrap (2→0). Go to HDR.
  - HDR: pulse `read_enb_g` for one cycle (the header read). Go to HWAIT.
  - HWAIT: wait for the header byte. Load `remaining` = len+1. Go to BODY.
  - BODY: issue reads while `remaining` > 0 and the issue rule holds; decrement `remaining` per read. When `remaining` reaches 0 and the last byte has been pushed into the buffer, go to IDLE and set `rr_ptr` = g+1 mod 3.
- Issue rule: assert `read_enb_g` only if `valid_out_g && (occ + inflight − pop) < 2`.
  - `occ`: number of entries in the 2-entry output buffer.
  - `inflight`: 0 or 1 read issued in the previous cycle.
  - `pop`: `m_valid && m_ready` this cycle.
- Only one `read_enb` is ever high. A read is never issued past the parity byte of the granted packet.
- Gaps: if `valid_out_g` drops mid-packet (writer slower than reader), the block stalls in BODY without losing position.
- Tagging: each byte is pushed into the buffer with its port, sop (header), eop (parity), and perr.
- Downstream limit: the consumer must not hold `m_ready` low for more than 25 cycles. Longer stalls can trigger the FIFO's 30-cycle soft-reset, which this block does not detect.
- Reset mid-packet: FSM goes to IDLE, `rr_ptr`=0, buffer is emptied, in-flight byte is discarded. Residual FIFO contents are the system's responsibility.

## Timing
- Reset values: `read_enb_*`=0, `m_valid`=0, `m_data`=0, `m_port`=0, `m_sop`=0, `m_eop`=0, `m_perr`=0.
- `read_enb` at cycle t → byte captured end of t+1 → byte on `m_*` at t+2.
- From IDLE, the header read is issued one cycle after `valid_out_N` is sampled high.
- There is one bubble cycle after the header read (HWAIT).
- With `m_ready`=1 and `valid_out_g`=1, the body streams at 1 byte/cycle. A len-L packet takes L+3 read-side cycles.
- IDLE is re-entered the cycle after the last read returns. There is no overlap between packets.
- Simultaneous requests are resolved by `rr_ptr` only. The grant is held for the whole packet.

## Configuration
- `ROUTER_DRAIN_ARB_PARITY_EN` defined:
  - Keep a running XOR of header and payload.
  - With the parity byte, set `m_perr` = (XOR ≠ parity byte).
  - Clear the running XOR on each header.
- Undefined: `m_perr` is tied to 0 and no XOR logic is built.

## Structure
- `router_pkg`:
  - FSM state enum (IDLE, HDR, HWAIT, BODY).
  - Header field positions: `HDR_LEN_MSB`=7, `HDR_LEN_LSB`=2.
  - `NUM_PORTS`=3.
  - Buffer entry struct {data, port, sop, eop, perr}.
- Sub-module `router_drain_skid`: 2-entry buffer with push/pop, `occ` output, and its own reset.

## Test plan
- Port 1 holds header 0x0D (len 3), bytes A,B,C, parity P; `m_ready`=1:
  - `read_enb_1` pulses t, t+2, t+3, t+4, t+5.
  - 5 bytes out with `m_port`=1.
  - `m_sop` on 0x0D, `m_eop` on P.
- All three ports hold one packet after reset:
  - Packets drain in order 0,1,2.
  - A fresh packet on port 0 and port 2 then drains port 0 first (`rr_ptr` has wrapped).
- Len-4 packet with `m_ready` low for 4 cycles mid-body:
  - No byte is lost or duplicated.
  - At most 2 bytes are buffered, and `read_enb` stays low during the stall.
- Header 0x02 (len 0) on port 2: exactly 2 reads; `m_sop` then `m_eop` on consecutive beats.
- Header 0x05 with payload 0x11 and a wrong parity byte:
  - `m_perr`=1 with `m_eop` when `ROUTER_DRAIN_ARB_PARITY_EN` is defined; 0 when undefined.
  - Correct parity (0x14) gives `m_perr`=0.
- `reset` asserted mid-body:
  - All outputs are 0 the next cycle.
  - After release, `rr_ptr`=0 and the next grant goes to the lowest valid port.
